mdu: RTL and testbench
======================

MDU -- requirements
Module: mdu

Interface
REQ-001 Parameter MULT_CYCLES, default 5: busy duration of a multiply, in cycles; legal range 1..15.
REQ-002 Parameter DIV_CYCLES, default 10: busy duration of a divide, in cycles; legal range 1..15.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; the block SHALL be reset when reset=0 at a rising edge of clk.
REQ-005 start  input  1  request strobe; sampled with op at each rising edge.
REQ-006 op  input  3  operation code: 0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; codes 6 and 7 are reserved.
REQ-007 a  input  32  operand A (rs value).
REQ-008 b  input  32  operand B (rt value).
REQ-009 busy  output  1  high while an operation is in progress.
REQ-010 hi  output  32  HI register; feeds the downstream 2:1 result mux.
REQ-011 lo  output  32  LO register; feeds the downstream 2:1 result mux.

Function
REQ-012 The block SHALL implement two states: IDLE and RUN.
REQ-013 IDLE, start=1, op is MULT, MULTU, DIV or DIVU: the block SHALL latch a, b and op, load the cycle counter with the cycle count for that op, and enter RUN at that edge.
REQ-014 RUN: busy=1; the counter SHALL decrement by 1 each cycle; when the counter reaches 1, the next edge SHALL write hi/lo and return to IDLE.
REQ-015 Latency: start accepted at edge t0 -> busy=1 for exactly N cycles (edges t0+1..t0+N, N=MULT_CYCLES or DIV_CYCLES); new hi/lo are visible in the same cycle busy returns to 0.
REQ-016 busy SHALL be a registered output and SHALL be 0 in the cycle start is first presented (the hazard unit stalls on start|busy).
REQ-017 MULT: the 64-bit signed product of a and b; MULTU: the 64-bit unsigned product; {hi,lo} SHALL equal the product.
REQ-018 DIV: lo = signed quotient truncated toward zero; hi = remainder with the sign of the dividend.
REQ-019 DIVU: lo and hi SHALL be the unsigned quotient and remainder.
REQ-020 Signed DIV of 0x80000000 by 0xFFFFFFFF SHALL yield lo=0x80000000, hi=0.
REQ-021 Divide by zero (b=0 latched): the full busy period SHALL still run, and hi and lo SHALL remain unchanged.
REQ-022 MTHI/MTLO in IDLE with start=1: hi (or lo) SHALL take a at that edge; busy SHALL stay 0 and the other register SHALL be unchanged.
REQ-023 Any start presented while in RUN SHALL be ignored, including MTHI/MTLO; the latched operands and op SHALL be unaffected.
REQ-024 start with a reserved op (6 or 7) SHALL be ignored; the block SHALL stay in IDLE.
REQ-025 Operands SHALL be captured only at acceptance; changes on a and b during RUN SHALL have no effect on the result.
REQ-026 The cycle after completion (IDLE), a new start SHALL be accepted; there SHALL be no dead cycle.
REQ-027 The block SHALL use no multicycle paths; the result SHALL be computed from registered operands and SHALL be written only at the completion edge.

Reset
REQ-028 On reset, hi, lo, busy and the counter SHALL be set to 0 and the state to IDLE.
REQ-029 Reset asserted during RUN SHALL abort the operation, with no hi/lo write and busy=0 at the next cycle.
REQ-030 Reset SHALL take priority over start in the same cycle.

Verification
REQ-031 MULT with a=0xFFFFFFFE (-2), b=3 -> busy high for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-032 MULTU with a=0xFFFFFFFF, b=2 -> hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles.
REQ-033 DIV with a=-7 (0xFFFFFFF9), b=2 -> 10 busy cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-034 MTHI with a=0x12345678, then MTLO presented during a DIVU busy period -> hi=0x12345678 immediately; the MTLO is ignored and lo holds the DIVU quotient.
REQ-035 Divide by zero after MTLO with a=0xAA -> busy runs 10 cycles, then lo=0xAA and hi is unchanged.
REQ-036 Reset pulsed in the 3rd busy cycle of a MULT -> busy=0, hi=lo=0 the next cycle; a new start in the following cycle is accepted.

Source files
------------

// File: rtl/mdu.sv
// Multiply/divide unit with HI/LO result registers.
// A two-state sequencer (IDLE/RUN) accepts one operation at a time, holds the
// operands in registers, counts down a fixed busy period and writes HI/LO on
// the completion edge. The arithmetic itself is a single-cycle function of
// the registered operands, so the busy period only paces the pipeline stall.
//
// Handshake: start/op are sampled on every rising edge. A start is accepted
// only in IDLE with a valid op; busy is registered, so it is 0 in the cycle a
// start is first presented and 1 for exactly the programmed number of cycles
// afterwards. Any start while busy is dropped without side effects.
module mdu #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        o_dbg_state
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   localparam logic [3:0] LP_MULT_N = 4'(MULT_CYCLES);
   localparam logic [3:0] LP_DIV_N  = 4'(DIV_CYCLES);

   state_t      r_state;
   logic        r_busy;
   logic [3:0]  r_cnt;
   logic [31:0] r_a;
   logic [31:0] r_b;
   logic [2:0]  r_op;
   logic [31:0] r_hi;
   logic [31:0] r_lo;

   logic        w_signed_div;
   logic        w_a_neg;
   logic        w_b_neg;
   logic        w_b_zero;
   logic [31:0] w_na;
   logic [31:0] w_nb;
   logic [31:0] w_uq;
   logic [31:0] w_ur;
   logic [31:0] w_q;
   logic [31:0] w_r;
   logic [63:0] w_prod_s;
   logic [63:0] w_prod_u;
   logic        w_wr_en;
   logic [31:0] w_res_hi;
   logic [31:0] w_res_lo;

   // Signed divide is done on magnitudes and the signs are reapplied, which
   // also gives 0x80000000 / -1 = 0x80000000 with remainder 0 naturally.
   assign w_signed_div = (r_op == OP_DIV);
   assign w_a_neg      = w_signed_div & r_a[31];
   assign w_b_neg      = w_signed_div & r_b[31];
   assign w_b_zero     = (r_b == 32'd0);
   assign w_na         = w_a_neg ? (32'd0 - r_a) : r_a;
   assign w_nb         = w_b_neg ? (32'd0 - r_b) : r_b;
   assign w_uq         = w_b_zero ? 32'd0 : (w_na / w_nb);
   assign w_ur         = w_b_zero ? 32'd0 : (w_na % w_nb);
   assign w_q          = (w_a_neg ^ w_b_neg) ? (32'd0 - w_uq) : w_uq;
   assign w_r          = w_a_neg ? (32'd0 - w_ur) : w_ur;

   assign w_prod_s = $signed({{32{r_a[31]}}, r_a}) * $signed({{32{r_b[31]}}, r_b});
   assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};

   // Select the result for the latched op; a zero divisor suppresses the write.
   always_comb begin
      w_wr_en  = 1'b0;
      w_res_hi = r_hi;
      w_res_lo = r_lo;
      case (r_op)
         OP_MULT: begin
            w_wr_en  = 1'b1;
            w_res_hi = w_prod_s[63:32];
            w_res_lo = w_prod_s[31:0];
         end
         OP_MULTU: begin
            w_wr_en  = 1'b1;
            w_res_hi = w_prod_u[63:32];
            w_res_lo = w_prod_u[31:0];
         end
         OP_DIV, OP_DIVU: begin
            w_wr_en  = ~w_b_zero;
            w_res_hi = w_r;
            w_res_lo = w_q;
         end
         default: begin
            w_wr_en = 1'b0;
         end
      endcase
   end

   // Sequencer: accept in IDLE, count down in RUN, write HI/LO on completion.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= ST_IDLE;
         r_busy  <= 1'b0;
         r_cnt   <= 4'd0;
         r_a     <= 32'd0;
         r_b     <= 32'd0;
         r_op    <= 3'd0;
         r_hi    <= 32'd0;
         r_lo    <= 32'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  case (op)
                     OP_MULT, OP_MULTU: begin
                        r_a     <= a;
                        r_b     <= b;
                        r_op    <= op;
                        r_cnt   <= LP_MULT_N;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                     end
                     OP_DIV, OP_DIVU: begin
                        r_a     <= a;
                        r_b     <= b;
                        r_op    <= op;
                        r_cnt   <= LP_DIV_N;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                     end
                     OP_MTHI: r_hi <= a;
                     OP_MTLO: r_lo <= a;
                     default: ;
                  endcase
               end
            end
            ST_RUN: begin
               r_cnt <= r_cnt - 4'd1;
               if (r_cnt == 4'd1) begin
                  if (w_wr_en) begin
                     r_hi <= w_res_hi;
                     r_lo <= w_res_lo;
                  end
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign busy        = r_busy;
   assign hi          = r_hi;
   assign lo          = r_lo;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mdu.sv
// Bench for mdu: driver issues operations and pushes the expected busy length
// and {hi,lo} into a queue; a monitor pops and compares whenever busy falls.
module tb_mdu;

   localparam int MC = 5;
   localparam int DC = 10;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  op = 3'd0;
   logic [31:0] a = 32'd0;
   logic [31:0] b = 32'd0;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        dbg_state;

   logic [67:0] exp_q[$];
   int          vectors = 0;
   int          miscompares = 0;
   bit          skip_next = 1'b0;
   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;

   mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk        (clk),
      .reset      (rst_n),
      .start      (start),
      .op         (op),
      .a          (a),
      .b          (b),
      .busy       (busy),
      .hi         (hi),
      .lo         (lo),
      .o_dbg_state(dbg_state)
   );

   // clock
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: MIPS HI/LO semantics straight from the arithmetic definition.
   function automatic logic [63:0] ref_res(input logic [2:0] o, input logic [31:0] x,
                                           input logic [31:0] y, input logic [63:0] cur);
      longint      sx, sy, q, rm;
      logic [63:0] ux, uy, p;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = {32'd0, x};
      uy = {32'd0, y};
      case (o)
         3'd0: begin q = sx * sy; return q; end
         3'd1: begin p = ux * uy; return p; end
         3'd2: begin
            if (y == 32'd0) return cur;
            q  = sx / sy;
            rm = sx % sy;
            return {rm[31:0], q[31:0]};
         end
         3'd3: begin
            if (y == 32'd0) return cur;
            return {x % y, x / y};
         end
         default: return cur;
      endcase
   endfunction

   // monitor: compare on each falling edge of busy
   initial begin : monitor
      int          cnt;
      logic        pb;
      logic [67:0] e;
      cnt = 0;
      pb  = 1'b0;
      forever begin
         @(negedge clk);
         if (pb && !busy) begin
            if (skip_next) begin
               skip_next = 1'b0;
            end else if (exp_q.size() == 0) begin
               check("unexpected_done", 64'd1, 64'd0);
            end else begin
               e = exp_q.pop_front();
               check("busy_len", 64'(cnt), {60'd0, e[67:64]});
               check("hi", {32'd0, hi}, {32'd0, e[63:32]});
               check("lo", {32'd0, lo}, {32'd0, e[31:0]});
            end
            cnt = 0;
         end
         if (busy) cnt++;
         pb = busy;
      end
   end

   // Issue an arithmetic op at the current negedge and wait for completion.
   // noise: 0 = quiet, 1 = random starts while busy, 2 = MTLO while busy.
   task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input int noise);
      logic [63:0] r;
      int          n;
      int          guard;
      r = ref_res(o, x, y, {m_hi, m_lo});
      n = (o < 3'd2) ? MC : DC;
      exp_q.push_back({4'(n), r});
      m_hi = r[63:32];
      m_lo = r[31:0];
      check("busy_at_start", {63'd0, busy}, 64'd0);
      start = 1'b1; op = o; a = x; b = y;
      @(negedge clk);
      start = 1'b0; a = $urandom; b = $urandom;
      guard = 0;
      while (busy && guard < 40) begin
         if (noise == 1) begin
            start = 1'($urandom_range(0, 1));
            op    = 3'($urandom_range(0, 7));
            a     = $urandom;
            b     = $urandom;
         end else if (noise == 2) begin
            start = 1'b1;
            op    = 3'd5;
            a     = 32'hBADBAD00;
         end
         @(negedge clk);
         guard++;
      end
      start = 1'b0;
      if (guard == 0 || guard >= 40) check("busy_window", 64'(guard), 64'(n));
   endtask

   task automatic do_mt(input logic [2:0] o, input logic [31:0] x);
      if (o == 3'd4) m_hi = x; else m_lo = x;
      start = 1'b1; op = o; a = x; b = $urandom;
      @(negedge clk);
      start = 1'b0;
      check("mt_busy", {63'd0, busy}, 64'd0);
      check("mt_hi", {32'd0, hi}, {32'd0, m_hi});
      check("mt_lo", {32'd0, lo}, {32'd0, m_lo});
   endtask

   task automatic do_rsv();
      start = 1'b1; op = 3'($urandom_range(6, 7)); a = $urandom; b = $urandom;
      @(negedge clk);
      start = 1'b0;
      check("rsv_busy", {63'd0, busy}, 64'd0);
      check("rsv_hi", {32'd0, hi}, {32'd0, m_hi});
      check("rsv_lo", {32'd0, lo}, {32'd0, m_lo});
   endtask

   // stimulus
   initial begin : driver
      logic [31:0] x, y;
      int          sel;
      // reset with a competing start: reset must win
      rst_n = 1'b0; start = 1'b1; op = 3'd4; a = 32'hDEAD0000;
      repeat (3) @(negedge clk);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_hi", {32'd0, hi}, 64'd0);
      check("rst_lo", {32'd0, lo}, 64'd0);
      start = 1'b0; rst_n = 1'b1;
      @(negedge clk);

      do_op(3'd0, 32'hFFFFFFFE, 32'd3, 0);
      check("mult_neg_hi", {32'd0, hi}, 64'hFFFFFFFF);
      check("mult_neg_lo", {32'd0, lo}, 64'hFFFFFFFA);
      do_op(3'd1, 32'hFFFFFFFF, 32'd2, 0);
      check("multu_hi", {32'd0, hi}, 64'h1);
      check("multu_lo", {32'd0, lo}, 64'hFFFFFFFE);
      do_op(3'd2, 32'hFFFFFFF9, 32'd2, 0);
      check("div_neg_lo", {32'd0, lo}, 64'hFFFFFFFD);
      check("div_neg_hi", {32'd0, hi}, 64'hFFFFFFFF);
      do_mt(3'd4, 32'h12345678);
      check("mthi_now", {32'd0, hi}, 64'h12345678);
      do_op(3'd3, 32'd1000, 32'd7, 2);
      check("divu_lo_kept", {32'd0, lo}, 64'd142);
      do_mt(3'd5, 32'h000000AA);
      do_op(3'd2, 32'd5, 32'd0, 1);
      check("div0_lo", {32'd0, lo}, 64'hAA);
      check("div0_hi", {32'd0, hi}, 64'd6);
      do_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 0);
      check("div_ovf_lo", {32'd0, lo}, 64'h80000000);
      check("div_ovf_hi", {32'd0, hi}, 64'd0);
      do_rsv();
      do_rsv();

      // reset in the third busy cycle of a MULT aborts it
      start = 1'b1; op = 3'd0; a = 32'h00001234; b = 32'h00005678;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      skip_next = 1'b1;
      rst_n = 1'b0;
      @(negedge clk);
      check("abort_busy", {63'd0, busy}, 64'd0);
      check("abort_hi", {32'd0, hi}, 64'd0);
      check("abort_lo", {32'd0, lo}, 64'd0);
      m_hi = 32'd0; m_lo = 32'd0;
      rst_n = 1'b1;
      do_op(3'd1, 32'h00010000, 32'h00010000, 0);

      // randomized mix, back-to-back
      for (int i = 0; i < 60; i++) begin
         x   = $urandom;
         sel = $urandom_range(0, 5);
         y   = (sel == 0) ? 32'd0 : (sel == 1) ? 32'($urandom_range(1, 9)) : $urandom;
         if ($urandom_range(0, 4) == 0) x = -32'($urandom_range(0, 100));
         sel = $urandom_range(0, 11);
         if (sel < 8) do_op(3'(sel % 4), x, y, int'($urandom_range(0, 1)));
         else if (sel < 10) do_mt(3'(4 + sel % 2), x);
         else do_rsv();
      end

      repeat (2) @(negedge clk);
      check("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
